// File: rtl/btn_step_gen.sv
// btn_step_gen: two-button (up/down) step generator.
// Each raw button is synchronized, then debounced. A four-state FSM driven by
// the debounced levels turns presses into single-cycle add/sub steps, with a
// hold-to-repeat feature.
// Optional build macro BTN_STEP_GEN_ACCEL_EN: after 8 consecutive auto-repeat
// steps the repeat spacing drops to a quarter of REPEAT_PERIOD_CYC.
module btn_step_gen #(
  parameter int DEBOUNCE_CYC      = 250000,
  parameter int REPEAT_DELAY_CYC  = 12500000,
  parameter int REPEAT_PERIOD_CYC = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn,
  output logic       add,
  output logic       sub,
  output logic [1:0] held
);

  localparam int MAX_RPT = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int MAX_CYC = (MAX_RPT > DEBOUNCE_CYC) ? MAX_RPT : DEBOUNCE_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] T_DELAY    = TW'(REPEAT_DELAY_CYC);
  localparam logic [TW-1:0] T_PERIOD   = TW'(REPEAT_PERIOD_CYC);
  localparam logic [TW-1:0] T_ONE      = TW'(1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] held_q;

  // Two-flop synchronizer on the raw buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Independent debounce per button: count cycles the synchronized level has
  // differed from the accepted level; any return to the accepted level restarts.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic [DW-1:0] cnt_q, cnt_d;
      logic          lvl_q, lvl_d;

      // Next debounce count and accepted level for this button.
      always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q[gi] != lvl_q) begin
          if (cnt_q == DB_LAST) begin
            lvl_d = sync2_q[gi];
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end

      // Debounce counter and accepted level registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          lvl_q <= lvl_d;
        end
      end

      assign held_q[gi] = lvl_q;
    end
  endgenerate

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;     // 0 = up (add), 1 = down (sub)
  logic          add_q, add_d;
  logic          sub_q, sub_d;
  logic [1:0]    active;
  logic          expire;
  logic [TW-1:0] period_load;

  assign active = dir_q ? 2'b10 : 2'b01;
  assign expire = (timer_q <= T_ONE);

`ifdef BTN_STEP_GEN_ACCEL_EN
  logic [3:0] rep_cnt_q, rep_cnt_d;

  // Count consecutive auto-repeat steps; cleared whenever the FSM is not repeating.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (state_q == IDLE || state_q == LOCK) begin
      rep_cnt_d = 4'd0;
    end else if (held_q == active && expire && rep_cnt_q < 4'd8) begin
      rep_cnt_d = rep_cnt_q + 4'd1;
    end
  end

  // Acceleration counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_cnt_q <= 4'd0;
    else      rep_cnt_q <= rep_cnt_d;
  end

  assign period_load = (rep_cnt_d >= 4'd8) ? TW'(REPEAT_PERIOD_CYC / 4) : T_PERIOD;
`else
  assign period_load = T_PERIOD;
`endif

  // FSM state register together with the timer, direction and step outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= 1'b0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      add_q   <= add_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state logic; a direct switch to the other button leaves via IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (held_q == 2'b11)      state_d = LOCK;
        else if (held_q != 2'b00) state_d = DELAY;
      end
      DELAY, REPEAT: begin
        if (held_q == 2'b11)        state_d = LOCK;
        else if (held_q != active)  state_d = IDLE;
        else if (expire)            state_d = REPEAT;
      end
      LOCK: begin
        if (held_q == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Step pulses, timer reloads and latched direction.
  always_comb begin
    add_d   = 1'b0;
    sub_d   = 1'b0;
    dir_d   = dir_q;
    timer_d = (timer_q != '0) ? (timer_q - T_ONE) : '0;
    case (state_q)
      IDLE: begin
        if (held_q == 2'b01 || held_q == 2'b10) begin
          dir_d   = held_q[1];
          add_d   = ~held_q[1];
          sub_d   = held_q[1];
          timer_d = T_DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (held_q == active && expire) begin
          add_d   = ~dir_q;
          sub_d   = dir_q;
          timer_d = period_load;
        end
      end
      default: ;
    endcase
  end

  assign add  = add_q;
  assign sub  = sub_q;
  assign held = held_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// Directed bench for btn_step_gen with small timing parameters.
// Cycle k of a sequence is the k-th rising edge after the edge at which the
// button change was applied; outputs are sampled 1 time unit after each edge.
module tb_btn_step_gen;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic       add, sub;
  logic [1:0] held;

  always #5 clk = ~clk;

  btn_step_gen #(
    .DEBOUNCE_CYC     (DB),
    .REPEAT_DELAY_CYC (RD),
    .REPEAT_PERIOD_CYC(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .add (add),
    .sub (sub),
    .held(held)
  );

  typedef struct {
    string      name;
    logic [1:0] pattern;
    int         hold;
    int         n_add;
    int         n_sub;
    int         first;
    int         last;
  } vec_t;

  vec_t       vecs[8];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         k;
  int         both_hi;
  logic [1:0] held_or;
  int         add_t[$];
  int         sub_t[$];
  int         exp_add[$];
  int         exp_sub[$];
  int         act_t[$];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (add && sub) both_hi++;
    held_or = held_or | held;
    if (add) add_t.push_back(k);
    if (sub) sub_t.push_back(k);
  endtask

  task automatic start_seq();
    k = 0;
    both_hi = 0;
    held_or = 2'b00;
    add_t.delete();
    sub_t.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pulses(input string name);
    check({name, "_add_count"}, add_t.size(), exp_add.size());
    for (int i = 0; i < add_t.size() && i < exp_add.size(); i++)
      check($sformatf("%s_add[%0d]", name, i), add_t[i], exp_add[i]);
    check({name, "_sub_count"}, sub_t.size(), exp_sub.size());
    for (int i = 0; i < sub_t.size() && i < exp_sub.size(); i++)
      check($sformatf("%s_sub[%0d]", name, i), sub_t[i], exp_sub[i]);
    check({name, "_exclusive"}, both_hi, 0);
    check({name, "_held_end"}, int'(held), 0);
    $display("[TB] %s: %0d add, %0d sub pulses", name, add_t.size(), sub_t.size());
  endtask

  initial begin
    // Held-duration boundaries: 3 cycles is one short of the debounce window,
    // 28 releases just early enough to suppress the step at cycle 35.
    vecs[0] = '{"up_10",   2'b01, 10, 1, 0, 7, 7};
    vecs[1] = '{"dn_10",   2'b10, 10, 0, 1, 7, 7};
    vecs[2] = '{"dn_60",   2'b10, 60, 0, 6, 7, 59};
    vecs[3] = '{"up_3",    2'b01, 3,  0, 0, 0, 0};
    vecs[4] = '{"up_4",    2'b01, 4,  1, 0, 7, 7};
    vecs[5] = '{"both_20", 2'b11, 20, 0, 0, 0, 0};
    vecs[6] = '{"up_28",   2'b01, 28, 2, 0, 7, 27};
    vecs[7] = '{"up_29",   2'b01, 29, 3, 0, 7, 35};

    // Reset state
    rst = 1'b0;
    btn = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", int'(held), 0);
    check("reset_add", int'(add), 0);
    check("reset_sub", int'(sub), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Table-driven clean presses
    for (int v = 0; v < 8; v++) begin
      start_seq();
      btn = vecs[v].pattern;
      repeat (vecs[v].hold) step();
      btn = 2'b00;
      repeat (30) step();
      check({vecs[v].name, "_add_count"}, add_t.size(), vecs[v].n_add);
      check({vecs[v].name, "_sub_count"}, sub_t.size(), vecs[v].n_sub);
      act_t = (vecs[v].pattern == 2'b10) ? sub_t : add_t;
      if (vecs[v].n_add + vecs[v].n_sub > 0 && act_t.size() > 0) begin
        check({vecs[v].name, "_first"}, act_t[0], vecs[v].first);
        check({vecs[v].name, "_last"}, act_t[act_t.size()-1], vecs[v].last);
      end
      check({vecs[v].name, "_exclusive"}, both_hi, 0);
      check({vecs[v].name, "_held_end"}, int'(held), 0);
      $display("[TB] %s: %0d add, %0d sub pulses", vecs[v].name, add_t.size(), sub_t.size());
    end

    // Bouncing input: high for 2 cycles, low for 2, never long enough to accept
    start_seq();
    for (int i = 0; i < 20; i++) begin
      btn = (i % 2 == 0) ? 2'b01 : 2'b00;
      step();
      step();
    end
    btn = 2'b00;
    repeat (20) step();
    exp_add = {};
    exp_sub = {};
    check_pulses("bounce");
    check("bounce_held_never", int'(held_or), 0);

    // Second button joins at cycle 28 (held reaches 11 in time to block the
    // cycle-35 step), both released at 50 -> LOCK, then IDLE
    start_seq();
    btn = 2'b01;
    repeat (28) step();
    btn = 2'b11;
    repeat (22) step();
    btn = 2'b00;
    repeat (30) step();
    exp_add = '{7, 27};
    exp_sub = {};
    check_pulses("lock");

    // After LOCK the FSM is back in IDLE: a fresh press steps normally
    start_seq();
    btn = 2'b01;
    repeat (10) step();
    btn = 2'b00;
    repeat (30) step();
    exp_add = '{7};
    exp_sub = {};
    check_pulses("after_lock");

    // Direct switch up->down at cycle 12: held flips at 18, IDLE at 19, sub at 20
    start_seq();
    btn = 2'b01;
    repeat (12) step();
    btn = 2'b10;
    repeat (18) step();
    btn = 2'b00;
    repeat (30) step();
    exp_add = '{7};
    exp_sub = '{20};
    check_pulses("switch");

    // Reset mid-press after cycle 15 for 3 cycles; button re-debounced from 18
    start_seq();
    btn = 2'b01;
    repeat (15) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("midrst_held[%0d]", i), int'(held), 0);
      check($sformatf("midrst_add[%0d]", i), int'(add), 0);
      check($sformatf("midrst_sub[%0d]", i), int'(sub), 0);
    end
    rst = 1'b1;
    repeat (12) step();
    btn = 2'b00;
    repeat (30) step();
    exp_add = '{7, 18 + DB + 3};
    exp_sub = {};
    check_pulses("midrst");

`ifdef BTN_STEP_GEN_ACCEL_EN
    // Accelerated repeat: 8 repeats (27..83) spaced 8, then spacing 2
    start_seq();
    btn = 2'b01;
    repeat (200) step();
    btn = 2'b00;
    repeat (30) step();
    exp_add = '{7};
    for (int t = 27; t <= 83; t += RP) exp_add.push_back(t);
    for (int t = 83 + RP / 4; t <= 205; t += RP / 4) exp_add.push_back(t);
    exp_sub = {};
    check_pulses("accel");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
